sdram_frame_arbiter: RTL and testbench
======================================

# sdram_frame_arbiter

Frame-granular arbiter for the SDRAM write port (`sys_data`/`sys_we`) in the SDRAM-to-VGA display path. Two pixel sources share the port: the test-pattern generator and a second writer such as an image loader. Each source requests the port for one whole frame of `H_DISP*V_DISP` pixels, and ownership never changes mid-frame, so no frame is torn. Grants alternate round-robin, and every frame ends with a done or abort pulse.

## Interface
- `H_DISP`, 640: active pixels per line.
- `V_DISP`, 480: active lines per frame.
- `TIMEOUT_CYC`, 1024: idle-write watchdog limit in cycles. Used only with `ARB_TIMEOUT_EN`.
- `clk` input 1: single clock. All logic runs on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `sys_vaild` input 1: SDRAM controller ready.
- `req` input 2: per-source frame request, level-sensitive.
- `we0`, `we1` input 1 each: pixel strobe from each source.
- `data0`, `data1` input 24 each: RGB888 pixel from each source.
- `gnt` output 2: one-hot grant, or 0 when no source owns the port.
- `sys_data` output 24: muxed, registered pixel.
- `sys_we` output 1: registered write strobe.
- `frame_done` output 1: one-cycle pulse when a frame completes.
- `frame_abort` output 1: one-cycle pulse when a frame is aborted.
- `owner` output 1: index of the last granted source.

## Operation
- States: IDLE, GRANT, GAP.
- Reset values: state IDLE; `gnt`=0; `sys_data`=0; `sys_we`=0; `frame_done`=0; `frame_abort`=0; `owner`=1 (so source 0 wins first); pixel count 0.
- IDLE:
  - If `sys_vaild` is high and at least one `req` bit is set, pick a winner round-robin: the requester other than `owner` has priority.
  - Set `gnt` one-hot, set `owner` to the winner, clear the pixel count, go to GRANT.
- GRANT, per-cycle data path:
  - `sys_we` <= `weN` of the granted source.
  - `sys_data` <= `dataN` of the granted source when `weN` is high; otherwise `sys_data` holds.
  - Strobes from the non-granted source are ignored and never reach `sys_we`.
- GRANT, counting:
  - Each granted `we` increments the pixel count.
  - The count width is ceil(log2(H_DISP*V_DISP+1)), which is 19 bits at the defaults.
- GRANT, completion: when the count equals `H_DISP*V_DISP-1` and `we` is high (the last pixel):
  - forward the pixel;
  - clear `gnt` and pulse `frame_done` on the same edge;
  - go to GAP.
- GRANT, abort: if `sys_vaild` falls before the frame completes:
  - clear `gnt`, force `sys_we` to 0, pulse `frame_abort`, clear the count, go to GAP;
  - `owner` keeps its value, so the other source has priority next.
- GAP: exactly one cycle with `sys_we`=0 and `gnt`=0, then IDLE. This guarantees a bubble between frames.
- Deasserting `req` during GRANT has no effect. A grant ends only by completion or abort.
- With only one source requesting, that source is granted again after the GAP cycle.

## Timing
- `req` high in IDLE -> `gnt` high on the next edge. Grant latency is 1 cycle.
- `weN`/`dataN` -> `sys_we`/`sys_data`: 1-cycle registered latency.
- The last pixel is forwarded on the same edge that clears `gnt`. A `we` in the following cycle is dropped.
- Minimum spacing between grants: 2 cycles (the GAP cycle, then IDLE's grant edge).
- `frame_done` and `frame_abort` are never high in the same cycle. If `sys_vaild` falls in the cycle of the last pixel, the outcome is completion (done wins).
- `rst` asserted mid-frame: all outputs return to reset values immediately, with no done or abort pulse.

## Configuration
- `ARB_TIMEOUT_EN` defined:
  - A watchdog counter runs in GRANT and clears on every granted `we`.
  - When it reaches `TIMEOUT_CYC`, the frame aborts exactly as for loss of `sys_vaild`: `frame_abort` pulse, `gnt` cleared, GAP.
- `ARB_TIMEOUT_EN` undefined:
  - No watchdog counter exists.
  - A stalled owner holds the port indefinitely; only `sys_vaild` loss or `rst` releases it.

## Structure
- Shared package `sdram_arb_pkg` holds:
  - the state encoding (IDLE=0, GRANT=1, GAP=2);
  - the RGB888 width constant (24);
  - the frame-size function `H_DISP*V_DISP`.
- One sub-module, `frame_pixel_counter`:
  - inputs: clear, increment;
  - output: last-pixel flag, asserted when the count equals N-1 with increment high;
  - parameterised on `H_DISP`/`V_DISP`.
- The arbiter FSM, mux and watchdog live in the top module.

## Test plan
- Reset, then `req`=2'b11 with `sys_vaild`=1 -> `gnt`=01 one cycle later and `owner`=0.
- Source 0 streams with `H_DISP`=4, `V_DISP`=2: 8 strobes with data 0x000001..0x000008 -> `sys_data` shows 1..8 at 1-cycle latency, `frame_done` pulses once, `gnt`=00, one GAP cycle follows, then `gnt`=10.
- During source 1's grant, source 0 toggles `we0` -> `sys_we` follows `we1` only.
- `sys_vaild` falls after 3 of 8 pixels -> `frame_abort` pulse, no `frame_done`, `sys_we`=0; after `sys_vaild` returns, source 0 (the other source) is granted next.
- With `ARB_TIMEOUT_EN` and `TIMEOUT_CYC`=16, the owner stops strobing -> `frame_abort` fires on the 16th idle cycle. Without the macro, `gnt` stays held for more than 100 cycles.
- `rst` pulsed mid-frame -> `gnt`=0, `sys_we`=0, `owner`=1 immediately; the next grant goes to source 0.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// Shared definitions for the SDRAM write-port frame arbiter: state codes,
// pixel width and frame-size helper.
package sdram_arb_pkg;

  localparam int RGB_W = 24;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  function automatic int frame_pixels(input int h_disp, input int v_disp);
    return h_disp * v_disp;
  endfunction

endpackage

// File: rtl/frame_pixel_counter.sv
// Counts granted pixel strobes within one frame and flags the strobe that
// carries the final pixel of the frame.
module frame_pixel_counter
  import sdram_arb_pkg::*;
#(
  parameter int H_DISP = 640,
  parameter int V_DISP = 480
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic inc,
  output logic last
);

  localparam int N  = frame_pixels(H_DISP, V_DISP);
  localparam int CW = $clog2(N + 1);

  logic [CW-1:0] count;

  assign last = inc && (count == CW'(N - 1));

  // clear wins over inc so an aborted frame never leaves a stale count behind
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      if (last) count <= '0;
      else      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/sdram_frame_arbiter.sv
// Frame-granular round-robin arbiter for the SDRAM write port.
// Optional idle-write watchdog enabled by defining ARB_TIMEOUT_EN.
module sdram_frame_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int H_DISP      = 640,
  parameter int V_DISP      = 480,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sys_vaild,
  input  logic [1:0]       req,
  input  logic             we0,
  input  logic             we1,
  input  logic [RGB_W-1:0] data0,
  input  logic [RGB_W-1:0] data1,
  output logic [1:0]       gnt,
  output logic [RGB_W-1:0] sys_data,
  output logic             sys_we,
  output logic             frame_done,
  output logic             frame_abort,
  output logic             owner
);

  logic [1:0]       state;
  logic             we_g;
  logic [RGB_W-1:0] data_g;
  logic             winner;
  logic             last_pix;
  logic             timeout;
  logic             abort_go;
  logic             cnt_clear;
  logic             cnt_inc;

  // During GRANT, owner always names the source that holds the port
  assign we_g   = owner ? we1 : we0;
  assign data_g = owner ? data1 : data0;
  assign winner = (owner ? req[0] : req[1]) ? ~owner : owner;

`ifdef ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

  logic [WD_W-1:0] wd_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt <= '0;
    end else if (state != ST_GRANT || we_g) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  assign timeout = (state == ST_GRANT) && !we_g && (wd_cnt == WD_W'(TIMEOUT_CYC - 1));
`else
  assign timeout = 1'b0;
`endif

  // A last pixel completes the frame even if sys_vaild drops on the same cycle
  always_comb begin
    abort_go  = 1'b0;
    cnt_clear = 1'b0;
    cnt_inc   = 1'b0;
    if (state == ST_GRANT) begin
      abort_go = !last_pix && (!sys_vaild || timeout);
      cnt_inc  = we_g;
    end
    cnt_clear = (state == ST_IDLE) || abort_go;
  end

  frame_pixel_counter #(
    .H_DISP(H_DISP),
    .V_DISP(V_DISP)
  ) u_pixel_counter (
    .clk  (clk),
    .rst  (rst),
    .clear(cnt_clear),
    .inc  (cnt_inc),
    .last (last_pix)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      gnt         <= 2'b00;
      sys_data    <= '0;
      sys_we      <= 1'b0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      owner       <= 1'b1;
    end else begin
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      case (state)
        ST_IDLE: begin
          sys_we <= 1'b0;
          if (sys_vaild && (|req)) begin
            gnt   <= winner ? 2'b10 : 2'b01;
            owner <= winner;
            state <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (last_pix) begin
            sys_we     <= 1'b1;
            sys_data   <= data_g;
            gnt        <= 2'b00;
            frame_done <= 1'b1;
            state      <= ST_GAP;
          end else if (abort_go) begin
            sys_we      <= 1'b0;
            gnt         <= 2'b00;
            frame_abort <= 1'b1;
            state       <= ST_GAP;
          end else begin
            sys_we <= we_g;
            if (we_g) sys_data <= data_g;
          end
        end
        ST_GAP: begin
          sys_we <= 1'b0;
          gnt    <= 2'b00;
          state  <= ST_IDLE;
        end
        default: begin
          sys_we <= 1'b0;
          gnt    <= 2'b00;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_frame_arbiter.sv
// Self-checking bench for sdram_frame_arbiter against a frame-level reference
// model; honours ARB_TIMEOUT_EN when the build defines it.
module tb_sdram_frame_arbiter;

  localparam int H_DISP = 4;
  localparam int V_DISP = 2;
  localparam int FRAME  = H_DISP * V_DISP;
  localparam int TO_CYC = 16;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        sys_vaild;
  logic [1:0]  req;
  logic        we0, we1;
  logic [23:0] data0, data1;
  logic [1:0]  gnt;
  logic [23:0] sys_data;
  logic        sys_we;
  logic        frame_done;
  logic        frame_abort;
  logic        owner;

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the port, how many pixels it has delivered,
  // how long it has been silent, and whether the post-frame bubble is pending.
  bit          m_busy;
  bit          m_gap;
  int          m_owner;
  int          m_pixels;
  int          m_idle;
  logic [1:0]  e_gnt;
  logic        e_we;
  logic [23:0] e_data;
  logic        e_done;
  logic        e_abort;

  sdram_frame_arbiter #(
    .H_DISP     (H_DISP),
    .V_DISP     (V_DISP),
    .TIMEOUT_CYC(TO_CYC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sys_vaild  (sys_vaild),
    .req        (req),
    .we0        (we0),
    .we1        (we1),
    .data0      (data0),
    .data1      (data1),
    .gnt        (gnt),
    .sys_data   (sys_data),
    .sys_we     (sys_we),
    .frame_done (frame_done),
    .frame_abort(frame_abort),
    .owner      (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".gnt"},   32'(gnt),         32'(e_gnt));
    checkOutput({tag, ".we"},    32'(sys_we),      32'(e_we));
    checkOutput({tag, ".data"},  32'(sys_data),    32'(e_data));
    checkOutput({tag, ".done"},  32'(frame_done),  32'(e_done));
    checkOutput({tag, ".abort"}, 32'(frame_abort), 32'(e_abort));
    checkOutput({tag, ".owner"}, 32'(owner),       32'(m_owner));
  endtask

  task automatic modelReset();
    m_busy = 0; m_gap = 0; m_owner = 1; m_pixels = 0; m_idle = 0;
    e_gnt = 2'b00; e_we = 1'b0; e_data = '0; e_done = 1'b0; e_abort = 1'b0;
  endtask

  task automatic modelStep();
    int          other;
    logic        w;
    logic [23:0] d;
    e_done  = 1'b0;
    e_abort = 1'b0;
    if (m_gap) begin
      m_gap = 0;
      e_gnt = 2'b00;
      e_we  = 1'b0;
    end else if (!m_busy) begin
      e_we = 1'b0;
      if (sys_vaild && req != 2'b00) begin
        other    = 1 - m_owner;
        m_owner  = req[other] ? other : m_owner;
        m_busy   = 1;
        m_pixels = 0;
        m_idle   = 0;
        e_gnt    = (m_owner == 1) ? 2'b10 : 2'b01;
      end
    end else begin
      w = (m_owner == 1) ? we1 : we0;
      d = (m_owner == 1) ? data1 : data0;
      if (w && m_pixels == FRAME - 1) begin
        e_we = 1'b1; e_data = d; e_done = 1'b1; e_gnt = 2'b00;
        m_busy = 0; m_gap = 1;
      end else if (!sys_vaild || (TO_EN && !w && m_idle + 1 == TO_CYC)) begin
        e_we = 1'b0; e_abort = 1'b1; e_gnt = 2'b00;
        m_busy = 0; m_gap = 1;
      end else begin
        e_we = w;
        if (w) begin
          e_data = d;
          m_pixels++;
          m_idle = 0;
        end else begin
          m_idle++;
        end
      end
    end
  endtask

  // Inputs are applied one time unit after an edge; the model consumes them,
  // the edge happens, and outputs are compared one unit later.
  task automatic applyStimulus(input string tag, input logic [1:0] r, input logic v,
                               input logic w0, input logic [23:0] d0,
                               input logic w1, input logic [23:0] d1);
    req = r; sys_vaild = v; we0 = w0; data0 = d0; we1 = w1; data1 = d1;
    modelStep();
    @(posedge clk);
    #1;
    checkAll(tag);
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    #1;
    modelReset();
    checkAll("rst_async");
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; sys_vaild = 1'b0; req = 2'b00;
    we0 = 1'b0; we1 = 1'b0; data0 = '0; data1 = '0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkAll("reset");
    rst = 1'b0;

    applyStimulus("first_grant", 2'b11, 1'b1, 1'b0, 24'h0, 1'b0, 24'h0);
    checkOutput("first_grant.gnt01", 32'(gnt), 32'h1);

    for (int i = 1; i <= FRAME; i++)
      applyStimulus("src0_stream", 2'b11, 1'b1, 1'b1, 24'(i), 1'($urandom), 24'($urandom));
    checkOutput("src0_last_data", 32'(sys_data), 32'h8);
    applyStimulus("gap_drop", 2'b11, 1'b1, 1'b1, 24'h9, 1'b0, 24'h0);
    applyStimulus("grant_src1", 2'b11, 1'b1, 1'b0, 24'h0, 1'b0, 24'h0);
    checkOutput("grant_src1.gnt10", 32'(gnt), 32'h2);

    for (int k = 0; k < 60 && m_busy; k++)
      applyStimulus("src1_ignore_we0", 2'b11, 1'b1, 1'($urandom), 24'($urandom),
                    1'($urandom), 24'($urandom));
    applyStimulus("gap2", 2'b11, 1'b1, 1'b0, 24'h0, 1'b0, 24'h0);
    applyStimulus("grant_src0", 2'b11, 1'b1, 1'b0, 24'h0, 1'b0, 24'h0);
    for (int i = 0; i < FRAME; i++)
      applyStimulus("src0_frame", 2'b11, 1'b1, 1'b1, 24'($urandom), 1'b0, 24'h0);
    applyStimulus("gap3", 2'b11, 1'b1, 1'b0, 24'h0, 1'b0, 24'h0);
    applyStimulus("grant_src1b", 2'b11, 1'b1, 1'b0, 24'h0, 1'b0, 24'h0);
    for (int i = 0; i < 3; i++)
      applyStimulus("src1_pre_abort", 2'b11, 1'b1, 1'b0, 24'h0, 1'b1, 24'(16 + i));
    applyStimulus("abort", 2'b11, 1'b0, 1'b0, 24'h0, 1'b1, 24'h77);
    checkOutput("abort.pulse", 32'(frame_abort), 32'h1);
    for (int i = 0; i < 3; i++)
      applyStimulus("vaild_low", 2'b11, 1'b0, 1'b0, 24'h0, 1'b0, 24'h0);
    applyStimulus("regrant_after_abort", 2'b11, 1'b1, 1'b0, 24'h0, 1'b0, 24'h0);
    checkOutput("regrant_after_abort.gnt01", 32'(gnt), 32'h1);

    for (int i = 0; i < 120; i++)
      applyStimulus("stall", 2'b01, 1'b1, 1'b0, 24'h0, 1'b0, 24'h0);
    for (int i = 0; i < 3; i++)
      applyStimulus("release", 2'b00, 1'b0, 1'b0, 24'h0, 1'b0, 24'h0);

    applyStimulus("single_grant", 2'b01, 1'b1, 1'b0, 24'h0, 1'b0, 24'h0);
    for (int i = 0; i < FRAME - 1; i++)
      applyStimulus("single_stream", 2'b01, 1'b1, 1'b1, 24'($urandom), 1'b0, 24'h0);
    applyStimulus("done_wins", 2'b01, 1'b0, 1'b1, 24'hABCDEF, 1'b0, 24'h0);
    checkOutput("done_wins.done", 32'(frame_done), 32'h1);
    applyStimulus("single_gap", 2'b01, 1'b1, 1'b0, 24'h0, 1'b0, 24'h0);
    applyStimulus("single_regrant", 2'b01, 1'b1, 1'b0, 24'h0, 1'b0, 24'h0);
    checkOutput("single_regrant.gnt01", 32'(gnt), 32'h1);

    for (int i = 0; i < 2; i++)
      applyStimulus("pre_reset", 2'b01, 1'b1, 1'b1, 24'($urandom), 1'b0, 24'h0);
    pulseReset();
    applyStimulus("post_reset_grant", 2'b11, 1'b1, 1'b0, 24'h0, 1'b0, 24'h0);
    checkOutput("post_reset_grant.gnt01", 32'(gnt), 32'h1);

    for (int i = 0; i < 400; i++)
      applyStimulus("random", 2'($urandom), ($urandom_range(0, 15) != 0),
                    1'($urandom), 24'($urandom), 1'($urandom), 24'($urandom));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
